// File: rtl/timer_share_scheduler_if.sv
// -----------------------------------------------------------------------------
// timer_share_scheduler_if
//   Avalon-style write-only bus to the SOPC interval timer's 16-bit register
//   slave, plus the timer's level interrupt.
//
//   Signals:
//     tmr_address     3   timer register address (0 status, 1 control,
//                         2 period_l, 3 period_h)
//     tmr_chipselect  1   write strobe qualifier
//     tmr_write_n     1   active-low write
//     tmr_writedata   16  write data
//     tmr_irq         1   timer interrupt, level, held until a status write
//
//   Modports:
//     master  the scheduler (drives the bus, samples irq)
//     slave   the timer (samples the bus, drives irq)
// -----------------------------------------------------------------------------
interface timer_share_scheduler_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/timer_share_scheduler.sv
// -----------------------------------------------------------------------------
// timer_share_scheduler
//   Shares one SOPC interval timer between NUM_REQ requesters that each need a
//   one-shot delay. Requesters are granted round-robin; for the winner the
//   block clears the timer status, loads period_l/period_h, starts the timer in
//   one-shot mode, waits for irq, clears status and pulses done for the winner.
//   Dropping req while waiting stops the timer and ends the grant with no done.
//
//   Parameters:
//     NUM_REQ      number of requesters (2..8)
//     WDOG_CYCLES  WAIT-state cycle limit (watchdog build only)
//
//   Ports:
//     clk         system clock, rising edge
//     reset       asynchronous, active-high reset
//     req         level request per requester
//     req_period  flat 32-bit period per requester, requester i at [32i+31:32i]
//     done        one-cycle pulse: delay complete for requester i
//     err         one-cycle pulse: watchdog abort for requester i
//     busy        high in every state except IDLE
//     tmr         timer bus (master modport)
//
//   Build option:
//     TMR_SCHED_WDOG_EN  when defined, a watchdog bounds the WAIT state to
//                        WDOG_CYCLES cycles and reports aborts on err; when
//                        undefined, WAIT is unbounded and err is constant 0.
// -----------------------------------------------------------------------------
module timer_share_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] WDOG_CYCLES = 32'h00FF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_period,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   busy,
  timer_share_scheduler_if.master tmr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0]  A_STATUS   = 3'd0;
  localparam logic [2:0]  A_CONTROL  = 3'd1;
  localparam logic [2:0]  A_PERIOD_L = 3'd2;
  localparam logic [2:0]  A_PERIOD_H = 3'd3;
  localparam logic [15:0] CTRL_START = 16'h0005;  // ITO | START, one-shot
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_WR_STAT, S_WR_PL, S_WR_PH, S_WR_CTRL,
    S_WAIT, S_CLR_DONE, S_CANCEL, S_CLR_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] grant_next;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic [31:0]      period_q;
  logic [31:0]      periods [NUM_REQ];
  logic             wdog_expire;

  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [15:0]      wr_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign periods[i] = req_period[32*i +: 32];
  end

  // Round-robin search: first requester at or after rr_q, wrapping.
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(rr_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!arb_found && req[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign grant_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (|req) state_d = S_ARB;
      S_ARB:       state_d = arb_found ? S_WR_STAT : S_IDLE;
      S_WR_STAT:   state_d = S_WR_PL;
      S_WR_PL:     state_d = S_WR_PH;
      S_WR_PH:     state_d = S_WR_CTRL;
      S_WR_CTRL:   state_d = S_WAIT;
      // irq has priority over a simultaneous req drop or watchdog expiry.
      S_WAIT: begin
        if (tmr.tmr_irq)                      state_d = S_CLR_DONE;
        else if (!req[grant_q] || wdog_expire) state_d = S_CANCEL;
      end
      S_CANCEL:    state_d = S_CLR_ABORT;
      S_CLR_DONE,
      S_CLR_ABORT: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Grant, period latch and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q     <= '0;
      grant_q  <= '0;
      period_q <= '0;
    end else begin
      if (state_q == S_ARB && arb_found) begin
        grant_q  <= arb_idx;
        // A zero load never produces an irq edge, so clamp it to one.
        period_q <= (periods[arb_idx] == 32'd0) ? 32'd1 : periods[arb_idx];
      end
      if (state_q == S_CLR_DONE || state_q == S_CLR_ABORT) rr_q <= grant_next;
    end
  end

  // Output decode: each write state drives a single one-cycle bus write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = A_STATUS;
    wr_data = 16'h0000;
    done    = '0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_WR_STAT:   wr_en = 1'b1;
      S_WR_PL:     begin wr_en = 1'b1; wr_addr = A_PERIOD_L; wr_data = period_q[15:0];  end
      S_WR_PH:     begin wr_en = 1'b1; wr_addr = A_PERIOD_H; wr_data = period_q[31:16]; end
      S_WR_CTRL:   begin wr_en = 1'b1; wr_addr = A_CONTROL;  wr_data = CTRL_START;      end
      S_CANCEL:    begin wr_en = 1'b1; wr_addr = A_CONTROL;  wr_data = CTRL_STOP;       end
      S_CLR_DONE:  begin wr_en = 1'b1; done[grant_q] = 1'b1; end
      S_CLR_ABORT: wr_en = 1'b1;
      default:     ;
    endcase
  end

  assign tmr.tmr_chipselect = wr_en;
  assign tmr.tmr_write_n    = ~wr_en;
  assign tmr.tmr_address    = wr_addr;
  assign tmr.tmr_writedata  = wr_data;

`ifdef TMR_SCHED_WDOG_EN
  logic [31:0] wdog_cnt_q;
  logic        wdog_abort_q;

  // The counter sits at zero outside WAIT, so it is zero on WAIT entry and
  // expiry lands on the WDOG_CYCLES-th WAIT cycle.
  assign wdog_expire = (state_q == S_WAIT) && (wdog_cnt_q == WDOG_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_q   <= '0;
      wdog_abort_q <= 1'b0;
    end else begin
      wdog_cnt_q <= (state_q == S_WAIT) ? wdog_cnt_q + 32'd1 : 32'd0;
      if (state_q == S_ARB)                          wdog_abort_q <= 1'b0;
      else if (wdog_expire && !tmr.tmr_irq)          wdog_abort_q <= 1'b1;
    end
  end

  always_comb begin
    err = '0;
    if (state_q == S_CLR_ABORT && wdog_abort_q) err[grant_q] = 1'b1;
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_expire = 1'b0;
  assign err         = '0;
`endif

endmodule

// File: tb/tb_timer_share_scheduler.sv
// -----------------------------------------------------------------------------
// tb_timer_share_scheduler
//   Self-checking bench for timer_share_scheduler. A behavioural timer model
//   logs every bus write and raises irq a programmed number of cycles after a
//   START. Expected grants come from a round-robin model over the request
//   vector; expected write sequences come from the documented register map.
// -----------------------------------------------------------------------------
module tb_timer_share_scheduler;
  localparam int N = 4;
`ifdef TMR_SCHED_WDOG_EN
  localparam logic [31:0] WDOG      = 32'd50;
  localparam logic [31:0] V0_PERIOD = 32'h0000_0030;
`else
  localparam logic [31:0] WDOG      = 32'h00FF_FFFF;
  localparam logic [31:0] V0_PERIOD = 32'h0000_0100;
`endif

  typedef struct { int cyc; logic [2:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic [N-1:0] bits; } ev_t;
  typedef struct {
    logic [N-1:0] req;
    logic [31:0]  period;
    int           exp_grant;
    logic [15:0]  exp_pl;
    logic [15:0]  exp_ph;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [32*N-1:0]   req_period;
  logic [N-1:0]      done;
  logic [N-1:0]      err;
  logic              busy;

  timer_share_scheduler_if bus();

  timer_share_scheduler #(.NUM_REQ(N), .WDOG_CYCLES(WDOG)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_period (req_period),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .tmr        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- timer model and bus monitor ----------------
  logic        t_irq = 1'b0;
  logic        t_run = 1'b0;
  logic [31:0] t_cnt = '0;
  logic [15:0] t_pl  = '0;
  logic [15:0] t_ph  = '0;
  bit          irq_en = 1'b1;
  int          proto_err = 0;
  wr_t         wr_q[$];
  ev_t         done_q[$];
  ev_t         err_q[$];

  assign bus.tmr_irq = t_irq;

  function automatic wr_t mk_wr(input int c, input logic [2:0] a, input logic [15:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    return w;
  endfunction

  function automatic ev_t mk_ev(input int c, input logic [N-1:0] b);
    ev_t e;
    e.cyc = c; e.bits = b;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      t_irq <= 1'b0; t_run <= 1'b0; t_cnt <= '0; t_pl <= '0; t_ph <= '0;
    end else begin
      if (bus.tmr_chipselect !== ~bus.tmr_write_n) proto_err <= proto_err + 1;
      if (bus.tmr_chipselect && !bus.tmr_write_n) begin
        wr_q.push_back(mk_wr(cyc, bus.tmr_address, bus.tmr_writedata));
        case (bus.tmr_address)
          3'd0: t_irq <= 1'b0;
          3'd1: begin
            if (bus.tmr_writedata[3]) t_run <= 1'b0;
            else if (bus.tmr_writedata[2]) begin
              t_cnt <= {t_ph, t_pl};
              t_run <= 1'b1;
            end
          end
          3'd2: t_pl <= bus.tmr_writedata;
          3'd3: t_ph <= bus.tmr_writedata;
          default: ;
        endcase
      end else if (t_run) begin
        if (t_cnt == 32'd1) begin
          t_run <= 1'b0;
          t_irq <= irq_en;
        end else begin
          t_cnt <= t_cnt - 32'd1;
        end
      end
      if (done != '0) done_q.push_back(mk_ev(cyc, done));
      if (err  != '0) err_q.push_back(mk_ev(cyc, err));
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;
  int model_rr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    done_q.delete();
    err_q.delete();
  endtask

  function automatic int model_grant(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(model_rr + k) % N]) return (model_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s done", tag),      32'(done), 0);
    check($sformatf("%s err", tag),       32'(err), 0);
    check($sformatf("%s busy", tag),      32'(busy), 0);
    check($sformatf("%s chipselect", tag), 32'(bus.tmr_chipselect), 0);
    check($sformatf("%s write_n", tag),   32'(bus.tmr_write_n), 1);
    check($sformatf("%s address", tag),   32'(bus.tmr_address), 0);
    check($sformatf("%s writedata", tag), 32'(bus.tmr_writedata), 0);
  endtask

  task automatic compare_writes(input string name, input wr_t exp_q[$]);
    check($sformatf("%s write count", name), wr_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
      check($sformatf("%s write%0d addr/data", name, k),
            {13'b0, wr_q[k].addr, wr_q[k].data}, {13'b0, exp_q[k].addr, exp_q[k].data});
    for (int k = 1; k < 4 && k < wr_q.size(); k++)
      check($sformatf("%s write%0d cycle", name, k), wr_q[k].cyc - wr_q[0].cyc, k);
  endtask

  // mode 0: hold req until done; 1: drop req in first WAIT cycle (period >= 2);
  // 2: drop req in the cycle irq rises (period 1).
  task automatic run_txn(input string name, input logic [N-1:0] r, input logic [31:0] per,
                         input int mode, input int exp_g,
                         input logic [15:0] exp_pl, input logic [15:0] exp_ph);
    int          guard;
    logic [31:0] eff;
    wr_t         exp_q[$];
    eff = (per == 32'd0) ? 32'd1 : per;
    clear_logs();
    for (int i = 0; i < N; i++)
      req_period[32*i +: 32] = (i == exp_g) ? per : (32'h00A0_0000 | 32'($urandom_range(0, 255)));
    req   = r;
    guard = 0;
    while (wr_q.size() < 1 && guard < 20) begin step(); guard++; end
    // Period is latched by now; later changes must not reach the timer.
    for (int i = 0; i < N; i++) req_period[32*i +: 32] = $urandom;
    while (wr_q.size() < 4 && guard < 20) begin step(); guard++; end
    check($sformatf("%s programming started", name), 32'(wr_q.size() >= 4), 1);
    if (mode != 0) begin
      step();
      req = '0;
    end
    if (mode == 1) begin
      guard = 0;
      while (busy && guard < 20) begin step(); guard++; end
      check($sformatf("%s idle after cancel", name), 32'(busy), 0);
    end else begin
      guard = 0;
      while (done_q.size() == 0 && guard < 600) begin step(); guard++; end
      check($sformatf("%s done seen", name), 32'(done_q.size() != 0), 1);
      req = '0;
      step();
      check($sformatf("%s busy low after done", name), 32'(busy), 0);
    end
    step();

    exp_q.push_back(mk_wr(0, 3'd0, 16'h0000));
    exp_q.push_back(mk_wr(0, 3'd2, exp_pl));
    exp_q.push_back(mk_wr(0, 3'd3, exp_ph));
    exp_q.push_back(mk_wr(0, 3'd1, 16'h0005));
    if (mode == 1) exp_q.push_back(mk_wr(0, 3'd1, 16'h0008));
    exp_q.push_back(mk_wr(0, 3'd0, 16'h0000));
    compare_writes(name, exp_q);

    if (mode == 1) begin
      check($sformatf("%s no done on cancel", name), done_q.size(), 0);
      if (wr_q.size() >= 5)
        check($sformatf("%s stop cycle", name), wr_q[4].cyc - wr_q[3].cyc, 2);
    end else begin
      check($sformatf("%s done count", name), done_q.size(), 1);
      if (done_q.size() > 0) begin
        check($sformatf("%s done index", name), 32'(done_q[0].bits), 32'(1 << exp_g));
        if (wr_q.size() >= 5) begin
          check($sformatf("%s done latency", name), done_q[0].cyc - wr_q[3].cyc, eff + 1);
          check($sformatf("%s clear with done", name), wr_q[4].cyc, done_q[0].cyc);
        end
      end
    end
    check($sformatf("%s no err", name), err_q.size(), 0);
    model_rr = (exp_g + 1) % N;
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[6];

  initial begin
    int guard;
    int expg;
    int order_bad;

    // Grants assume the round-robin pointer is 1 on entry (after the
    // held-all-requests sequence below).
    vecs[0] = '{4'b0010, V0_PERIOD,     1, V0_PERIOD[15:0], 16'h0000};
    vecs[1] = '{4'b0001, 32'd0,         0, 16'h0001,        16'h0000};
    vecs[2] = '{4'b1001, 32'd3,         3, 16'h0003,        16'h0000};
    vecs[3] = '{4'b0110, 32'd7,         1, 16'h0007,        16'h0000};
    vecs[4] = '{4'b0110, 32'd2,         2, 16'h0002,        16'h0000};
    vecs[5] = '{4'b0001, 32'd5,         0, 16'h0005,        16'h0000};

    reset      = 1'b1;
    req        = '0;
    req_period = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();
    check("idle after reset busy", 32'(busy), 0);

    // All requesters held: grants rotate 0,1,2,3,0.
    clear_logs();
    for (int i = 0; i < N; i++) req_period[32*i +: 32] = 32'd10;
    req   = '1;
    guard = 0;
    while (done_q.size() < 5 && guard < 300) begin step(); guard++; end
    req = '0;
    step();
    step();
    check("held dones", done_q.size(), 5);
    for (int k = 0; k < 5 && k < done_q.size(); k++) begin
      expg = model_grant('1);
      check($sformatf("held grant%0d", k), 32'(done_q[k].bits), 32'(1 << expg));
      model_rr = (expg + 1) % N;
    end
    check("held write count", wr_q.size(), 25);
    order_bad = 0;
    for (int k = 1; k < wr_q.size(); k++) if (wr_q[k].cyc <= wr_q[k-1].cyc) order_bad++;
    check("held writes distinct cycles", order_bad, 0);

    // Table vectors.
    for (int v = 0; v < 6; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].period, 0,
              vecs[v].exp_grant, vecs[v].exp_pl, vecs[v].exp_ph);

    // Cancel requester 2 in WAIT; pointer must then sit at 3.
    run_txn("cancel2", 4'b0100, 32'h0002_0007, 1, 2, 16'h0007, 16'h0002);
    run_txn("rr after cancel", 4'b1001, 32'd4, 0, 3, 16'h0004, 16'h0000);

    // irq and req drop in the same WAIT cycle: done wins, no STOP.
    run_txn("irq with drop", 4'b0001, 32'd1, 2, 0, 16'h0001, 16'h0000);

    // Randomised transactions against the round-robin model.
    for (int it = 0; it < 12; it++) begin
      logic [N-1:0] r;
      logic [31:0]  p;
      logic [31:0]  eff;
      int           m;
      int           g;
      r   = N'($urandom_range(1, (1 << N) - 1));
      m   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      p   = (m == 1) ? 32'($urandom_range(2, 20)) : 32'($urandom_range(0, 20));
      g   = model_grant(r);
      eff = (p == 32'd0) ? 32'd1 : p;
      run_txn($sformatf("rand%0d", it), r, p, m, g, eff[15:0], eff[31:16]);
    end

    // Reset while waiting: outputs return at once, pointer back to 0.
    clear_logs();
    for (int i = 0; i < N; i++) req_period[32*i +: 32] = 32'd50;
    req   = 4'b0100;
    guard = 0;
    while (wr_q.size() < 4 && guard < 20) begin step(); guard++; end
    step();
    step();
    check("busy in wait", 32'(busy), 1);
    reset = 1'b1;
    req   = '0;
    #1;
    check_reset_outputs("mid reset");
    step();
    reset = 1'b0;
    step();
    model_rr = 0;
    run_txn("post reset", 4'b0011, 32'd3, 0, 0, 16'h0003, 16'h0000);

`ifdef TMR_SCHED_WDOG_EN
    begin
      wr_t exp_q[$];
      irq_en = 1'b0;
      clear_logs();
      for (int i = 0; i < N; i++) req_period[32*i +: 32] = 32'd5;
      expg  = model_grant(4'b0010);
      req   = 4'b0010;
      guard = 0;
      while (err_q.size() == 0 && guard < 200) begin step(); guard++; end
      req = '0;
      step();
      check("wdog err seen", 32'(err_q.size() != 0), 1);
      check("wdog busy low", 32'(busy), 0);
      exp_q.push_back(mk_wr(0, 3'd0, 16'h0000));
      exp_q.push_back(mk_wr(0, 3'd2, 16'h0005));
      exp_q.push_back(mk_wr(0, 3'd3, 16'h0000));
      exp_q.push_back(mk_wr(0, 3'd1, 16'h0005));
      exp_q.push_back(mk_wr(0, 3'd1, 16'h0008));
      exp_q.push_back(mk_wr(0, 3'd0, 16'h0000));
      compare_writes("wdog", exp_q);
      check("wdog no done", done_q.size(), 0);
      if (err_q.size() > 0) begin
        check("wdog err index", 32'(err_q[0].bits), 32'(1 << expg));
        if (wr_q.size() >= 6) begin
          check("wdog err latency", err_q[0].cyc - wr_q[3].cyc, int'(WDOG) + 2);
          check("wdog clear with err", wr_q[5].cyc, err_q[0].cyc);
        end
      end
      model_rr = (expg + 1) % N;
      irq_en   = 1'b1;
    end
`endif

    check("bus strobe consistency", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_share_scheduler.md
# timer_share_scheduler

Shares the single SOPC interval timer (16-bit register slave: status, control, period_l, period_h) between NUM_REQ hardware requesters, each needing a one-shot delay. The block is an Avalon-style write master on the timer's slave port. It arbitrates round-robin, programs period and control, waits for the timer's irq, clears status, and returns a done pulse to the winning requester. It sits between the requesters and the timer in the FPGA SOPC fabric.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WDOG_CYCLES, 32'h00FF_FFFF, watchdog limit in WAIT (used only with TMR_SCHED_WDOG_EN)
- clk  in  1  system clock; one clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  level request; held until done/err or dropped to cancel
- req_period  in  32*NUM_REQ  flat period per requester, requester i at [32i+31:32i]
- done  out  NUM_REQ  one-cycle pulse, delay complete for requester i
- err  out  NUM_REQ  one-cycle pulse, watchdog abort (constant 0 without macro)
- busy  out  1  high in every state except IDLE
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  write strobe qualifier
- tmr_write_n  out  1  active-low write
- tmr_writedata  out  16  write data
- tmr_irq  in  1  timer interrupt (level, held until status write)

## Operation
- Reset values: done=0, err=0, busy=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0. RR pointer=0, state IDLE.
- Timer map: 0 status (any write clears timeout), 1 control (b0 ITO, b1 CONT, b2 START, b3 STOP), 2 period_l, 3 period_h.
- Every write lasts exactly one cycle: chipselect=1 and write_n=0. There are no wait states and no reads.
- States and transitions:
  - IDLE: if any req bit is set, go to ARB.
  - ARB: grant the lowest index ≥ RR pointer with req set, wrapping. Latch the index g and req_period[g]. A latched period of 0 is clamped to 1, because a zero load produces no irq edge.
  - WR_STAT: write 0 to addr 0, clearing any stale timeout.
  - WR_PL: write period[15:0] to addr 2.
  - WR_PH: write period[31:16] to addr 3.
  - WR_CTRL: write 16'h0005 to addr 1 (ITO|START, one-shot).
  - WAIT: stay until tmr_irq=1, then go to CLR_DONE. If req[g] drops, go to CANCEL.
  - CLR_DONE: write 0 to addr 0, pulse done[g], set RR pointer to g+1 mod NUM_REQ, go to IDLE.
  - CANCEL: write 16'h0008 to addr 1 (STOP), then go to CLR_ABORT.
  - CLR_ABORT: write 0 to addr 0, no done pulse, advance RR pointer, go to IDLE.
- Requests rising outside IDLE wait; a requester is never preempted.
- req_period changes after ARB are ignored.
- If irq and a req[g] drop arrive in the same WAIT cycle, irq wins and done[g] pulses.

## Timing
- Cycle 0 = ARB. Writes are issued at cycles 1 (status), 2 (PL), 3 (PH), 4 (CTRL). WAIT starts at cycle 5.
- done[g] is asserted in the cycle following the first WAIT cycle that samples tmr_irq=1; the clear write is in that same cycle.
- Back-to-back: IDLE occupies one cycle between transactions. Minimum spacing between two ARB cycles is 8 cycles plus the irq wait.
- Reset mid-operation returns immediately to reset values. The timer is not stopped by this block; the timer shares the same reset.

## Configuration
- TMR_SCHED_WDOG_EN defined:
  - A 32-bit counter clears on WAIT entry and increments each WAIT cycle.
  - On reaching WDOG_CYCLES without irq, the block runs CANCEL then CLR_ABORT, and pulses err[g] in the CLR_ABORT cycle.
- Undefined: no counter, err tied to 0, WAIT is unbounded.

## Test plan
- req=4'b0010, period1=32'h0000_0100, timer model: writes at cycles 1-4 are addr0/0, addr2/0x0100, addr3/0x0000, addr1/0x0005; done[1] pulses once after irq; busy low one cycle later.
- req=4'b1111 held, all periods=10: grants follow 0,1,2,3,0, with exactly one done per grant and no overlapping writes.
- period0=0: the addr2 write carries 0x0001, irq arrives, and done[0] pulses.
- req[2] dropped in WAIT: addr1/0x0008 then addr0/0 are written, no done[2], and the RR pointer moves to 3.
- irq and req[g] drop in the same cycle: done[g] pulses and no STOP is written.
- With TMR_SCHED_WDOG_EN, WDOG_CYCLES=50, irq never asserted: STOP and clear are written, then err[g] pulses after 50 WAIT cycles. Reset asserted in WAIT: all outputs return to reset values immediately.
